// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: shared timebase derivations and pulse-width arithmetic for the servo PWM generator
package servo_pwm_pkg;

    localparam int HZ_PER_MHZ = 1_000_000;

    function automatic int ticks_per_us(input int clk_hz);
        return clk_hz / HZ_PER_MHZ;
    endfunction

    function automatic int center_us(input int min_us, input int max_us);
        return (min_us + max_us) / 2;
    endfunction

    function automatic int clamp_us(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    function automatic int slew_step(input int act, input int pend, input int step);
        return pend > act + step ? act + step : pend < act - step ? act - step : pend;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one servo channel holding the pending/active width and driving its pwm bit
module servo_pwm_channel
    import servo_pwm_pkg::*;
#(
    parameter int CMD_W   = 13,
    parameter int FU_W    = 15,
    parameter int CENTER  = 1500,
    parameter int SLEW_US = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CMD_W-1:0] wr_val,
    input  logic             boundary,
    input  logic [FU_W-1:0]  frame_us,
    output logic             pwm
);

    localparam int CW = CMD_W > FU_W ? CMD_W : FU_W;

`ifdef SERVO_PWM_SLEW_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif

    logic [CMD_W-1:0] pending;
    logic [CMD_W-1:0] active;
    logic [CMD_W-1:0] next_active;

    assign next_active = SLEW_ON ? CMD_W'(slew_step(int'(active), int'(pending), SLEW_US)) : pending;

    // buffer writes, promote them to the active width only at the frame boundary, and compare in us
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= CMD_W'(CENTER);
            active  <= CMD_W'(CENTER);
            pwm     <= 1'b0;
        end else begin
            if (wr)
                pending <= wr_val;
            if (boundary)
                active <= next_active;
            pwm <= en && (CW'(frame_us) < CW'(active));
        end
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel RC-servo PWM generator; optional per-frame slew limit via SERVO_PWM_SLEW_EN
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int NUM_CH   = 2,
    parameter int CMD_W    = 13,
    parameter int FRAME_US = 20000,
    parameter int MIN_US   = 1000,
    parameter int MAX_US   = 2000,
    parameter int SLEW_US  = 20,
    localparam int CH_W    = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CMD_W-1:0]  wr_data,
    output logic [NUM_CH-1:0] pwm,
    output logic              frame_start,
    output logic              clamp_hit
);

    localparam int TICKS  = ticks_per_us(CLK_HZ);
    localparam int PS_W   = TICKS > 1 ? $clog2(TICKS) : 1;
    localparam int FU_W   = $clog2(FRAME_US);
    localparam int CENTER = center_us(MIN_US, MAX_US);
    localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CH);

    logic [PS_W-1:0]  presc;
    logic [FU_W-1:0]  frame_us;
    logic             presc_wrap;
    logic             boundary;
    logic             wr_ok;
    logic             wr_clamped;
    logic [CMD_W-1:0] wr_val;

    assign presc_wrap = presc == PS_W'(TICKS - 1);
    assign boundary   = presc_wrap && frame_us == FU_W'(FRAME_US - 1);
    assign wr_ok      = wr_en && {1'b0, wr_ch} < NCH;
    assign wr_val     = CMD_W'(clamp_us(int'(wr_data), MIN_US, MAX_US));
    assign wr_clamped = clamp_us(int'(wr_data), MIN_US, MAX_US) != int'(wr_data);

    // shared timebase: tick prescaler feeding the microsecond frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            frame_us <= '0;
        end else begin
            presc <= presc_wrap ? '0 : presc + 1'b1;
            if (presc_wrap)
                frame_us <= boundary ? '0 : frame_us + 1'b1;
        end
    end

    // frame marker registered from the same counter state as pwm, plus the write clamp flag
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
            clamp_hit   <= 1'b0;
        end else begin
            frame_start <= presc == '0 && frame_us == '0;
            clamp_hit   <= wr_ok && wr_clamped;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_pwm_channel #(
            .CMD_W  (CMD_W),
            .FU_W   (FU_W),
            .CENTER (CENTER),
            .SLEW_US(SLEW_US)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .wr      (wr_ok && wr_ch == CH_W'(i)),
            .wr_val  (wr_val),
            .boundary(boundary),
            .frame_us(frame_us),
            .pwm     (pwm[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: frame-level directed checks of servo_pwm_multi at 2 ticks/us and a 100 us frame
module tb_servo_pwm_multi;

    // three channels so that wr_ch is two bits wide and channel 3 is an out-of-range target
    localparam int NCH   = 3;
    localparam int FRAME = 200;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b1;
    logic           wr_en = 1'b0;
    logic [1:0]     wr_ch = '0;
    logic [12:0]    wr_data = '0;
    logic [NCH-1:0] pwm;
    logic           frame_start;
    logic           clamp_hit;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          o1;
        logic [1:0]  c1;
        logic [12:0] d1;
        logic        k1;
        int          o2;
        logic [1:0]  c2;
        logic [12:0] d2;
        logic        k2;
        int          eo;
        int          w0;
        int          w1;
        int          w2;
    } vec_t;

    servo_pwm_multi #(
        .CLK_HZ  (2_000_000),
        .NUM_CH  (NCH),
        .CMD_W   (13),
        .FRAME_US(100),
        .MIN_US  (10),
        .MAX_US  (50),
        .SLEW_US (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .pwm        (pwm),
        .frame_start(frame_start),
        .clamp_hit  (clamp_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_frame(input string name);
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 2 * FRAME) begin
            step();
            n++;
        end
        chk({name, " frame_start seen"}, int'(frame_start === 1'b1), 1);
    endtask

    // entered at the sample where frame_start is high; leaves at the next frame's first sample
    task automatic run_frame(input vec_t v, input string tag);
        int cnt[NCH];
        int fs_ok;
        fs_ok = 1;
        for (int i = 0; i < NCH; i++) cnt[i] = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (frame_start !== (c == 0)) fs_ok = 0;
            for (int i = 0; i < NCH; i++) cnt[i] += int'(pwm[i] === 1'b1);
            if (v.o1 >= 0 && c == v.o1 + 1) chk({tag, " clamp_hit wr1"}, int'(clamp_hit), int'(v.k1));
            if (v.o2 >= 0 && c == v.o2 + 1) chk({tag, " clamp_hit wr2"}, int'(clamp_hit), int'(v.k2));
            if (v.eo >= 0 && c == v.eo + 5) chk({tag, " pwm while en=0"}, int'(pwm), 0);
            wr_en = 1'b0;
            if (c == v.o1) begin wr_en = 1'b1; wr_ch = v.c1; wr_data = v.d1; end
            if (c == v.o2) begin wr_en = 1'b1; wr_ch = v.c2; wr_data = v.d2; end
            en = !(v.eo >= 0 && c >= v.eo && c < v.eo + 10);
            step();
        end
        wr_en = 1'b0;
        en = 1'b1;
        chk({tag, " frame_start timing"}, fs_ok, 1);
        chk({tag, " ch0 high cycles"}, cnt[0], v.w0);
        chk({tag, " ch1 high cycles"}, cnt[1], v.w1);
        chk({tag, " ch2 high cycles"}, cnt[2], v.w2);
    endtask

    vec_t vt[10];
    vec_t nop;
    int   slew_w[5];

    initial begin
        nop = '{-1, 2'd0, 13'd0, 1'b0, -1, 2'd0, 13'd0, 1'b0, -1, 60, 60, 60};
        vt[0] = nop;
        vt[1] = '{198, 2'd0, 13'd40, 1'b0, -1, 2'd0, 13'd0, 1'b0, -1, 60, 60, 60};
        vt[2] = nop;
        vt[3] = '{-1, 2'd0, 13'd0, 1'b0, -1, 2'd0, 13'd0, 1'b0, -1, 80, 60, 60};
        vt[4] = '{100, 2'd0, 13'd20, 1'b0, -1, 2'd0, 13'd0, 1'b0, -1, 80, 60, 60};
        vt[5] = '{50, 2'd1, 13'd5, 1'b1, 60, 2'd1, 13'd80, 1'b1, -1, 40, 60, 60};
        vt[6] = '{70, 2'd3, 13'd5, 1'b0, -1, 2'd0, 13'd0, 1'b0, 20, 30, 90, 50};
        vt[7] = '{100, 2'd2, 13'd10, 1'b0, -1, 2'd0, 13'd0, 1'b0, -1, 40, 100, 60};
        vt[8] = '{100, 2'd2, 13'd50, 1'b0, -1, 2'd0, 13'd0, 1'b0, -1, 40, 100, 20};
        vt[9] = '{-1, 2'd0, 13'd0, 1'b0, -1, 2'd0, 13'd0, 1'b0, -1, 40, 100, 100};
`ifdef SERVO_PWM_SLEW_EN
        slew_w = '{70, 80, 90, 100, 100};
`else
        slew_w = '{100, 100, 100, 100, 100};
`endif

        repeat (3) step();
        chk("reset pwm", int'(pwm), 0);
        chk("reset frame_start", int'(frame_start), 0);
        chk("reset clamp_hit", int'(clamp_hit), 0);
        rst = 1'b0;
        sync_frame("initial");

`ifndef SERVO_PWM_SLEW_EN
        for (int k = 0; k < 10; k++) run_frame(vt[k], $sformatf("vec%0d", k));
`endif

        repeat (10) step();
        chk("pre-rst pwm high", int'(pwm), 7);
        rst = 1'b1;
        step();
        chk("rst pwm", int'(pwm), 0);
        chk("rst frame_start", int'(frame_start), 0);
        rst = 1'b0;
        step();
        chk("post-rst frame_start", int'(frame_start), 1);
        run_frame(nop, "post-rst");

        run_frame('{100, 2'd0, 13'd50, 1'b0, -1, 2'd0, 13'd0, 1'b0, -1, 60, 60, 60}, "wr50");
        for (int k = 0; k < 5; k++)
            run_frame('{-1, 2'd0, 13'd0, 1'b0, -1, 2'd0, 13'd0, 1'b0, -1, slew_w[k], 60, 60},
                      $sformatf("ramp%0d", k));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
